gmii_tx_framer: RTL and testbench



---
 rtl/gmii_tx_framer.sv | 214 +++++++++++++++++++++
 tb/tb_gmii_tx_framer.sv | 348 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/gmii_tx_framer.sv
// GMII transmit framer: wraps a payload byte stream into an Ethernet frame
// (preamble, SFD, payload, zero pad, CRC-32 FCS) and enforces the IFG.
//
// Ports:
//   GMII_TX_CLK_i  125 MHz transmit clock (rising edge)
//   RST_i          asynchronous active-high reset
//   TX_DATA_i      payload byte
//   TX_VALID_i     TX_DATA_i / TX_LAST_i valid
//   TX_LAST_i      final payload byte of the frame
//   TX_READY_o     beat accepted when TX_VALID_i && TX_READY_o
//   GMII_TX_TXD_o  GMII data to the RGMII output stage
//   GMII_TX_EN_o   GMII data valid
//   GMII_TX_ER_o   GMII error, asserted only for an underrun abort
//   TX_BUSY_o      high whenever the framer is not idle
//   FRAME_CNT_o    frames completed with FCS (wrapping)
//   ABORT_CNT_o    frames aborted by underrun (wrapping)
module gmii_tx_framer #(
    parameter int IFG_BYTES       = 12,
    parameter int MIN_FRAME_BYTES = 60
) (
    input  logic        GMII_TX_CLK_i,
    input  logic        RST_i,
    input  logic [7:0]  TX_DATA_i,
    input  logic        TX_VALID_i,
    input  logic        TX_LAST_i,
    output logic        TX_READY_o,
    output logic [7:0]  GMII_TX_TXD_o,
    output logic        GMII_TX_EN_o,
    output logic        GMII_TX_ER_o,
    output logic        TX_BUSY_o,
    output logic [15:0] FRAME_CNT_o,
    output logic [7:0]  ABORT_CNT_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_PRE, S_SFD, S_DATA, S_PAD, S_FCS, S_DROP, S_IFG
    } state_t;

    localparam logic [10:0] MIN_CNT  = 11'(MIN_FRAME_BYTES);
    localparam logic [7:0]  IFG_LAST = 8'(IFG_BYTES);

    function automatic logic [31:0] crc_byte(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c ^ {24'd0, d};
        for (int i = 0; i < 8; i++) begin
            r = r[0] ? ((r >> 1) ^ 32'hEDB88320) : (r >> 1);
        end
        return r;
    endfunction

    state_t      r_state;
    logic [2:0]  r_pre;
    logic [1:0]  r_idx;
    logic [7:0]  r_ifg;
    logic [10:0] r_cnt;
    logic [31:0] r_crc;
    logic [7:0]  r_txd;
    logic        r_en;
    logic        r_er;
    logic [15:0] r_frames;
    logic [7:0]  r_aborts;

    state_t      w_state_nxt;
    logic [2:0]  w_pre_nxt;
    logic [1:0]  w_idx_nxt;
    logic [7:0]  w_ifg_nxt;
    logic [10:0] w_cnt_nxt;
    logic [31:0] w_crc_nxt;
    logic [7:0]  w_txd_nxt;
    logic        w_en_nxt;
    logic        w_er_nxt;
    logic [15:0] w_frames_nxt;
    logic [7:0]  w_aborts_nxt;

    logic [10:0] w_cnt_inc;
    logic [11:0] w_diff;
    logic        w_need_pad;
    logic [31:0] w_fcs_sh;

    // Byte count after the byte being emitted this cycle; saturates.
    assign w_cnt_inc  = (r_cnt == 11'h7FF) ? r_cnt : r_cnt + 11'd1;
    // Sign of (count - minimum) avoids a constant compare when minimum is 0.
    assign w_diff     = {1'b0, w_cnt_inc} - {1'b0, MIN_CNT};
    assign w_need_pad = w_diff[11];
    assign w_fcs_sh   = (~r_crc) >> {r_idx, 3'b000};

    // Output registers are loaded with the byte for the coming cycle, so an
    // accepted beat is on the wire right after the edge that accepts it.
    always_comb begin
        w_state_nxt  = r_state;
        w_pre_nxt    = r_pre;
        w_idx_nxt    = r_idx;
        w_ifg_nxt    = r_ifg;
        w_cnt_nxt    = r_cnt;
        w_crc_nxt    = r_crc;
        w_txd_nxt    = 8'h00;
        w_en_nxt     = 1'b0;
        w_er_nxt     = 1'b0;
        w_frames_nxt = r_frames;
        w_aborts_nxt = r_aborts;
        unique case (r_state)
            S_IDLE: begin
                if (TX_VALID_i) begin
                    w_state_nxt = S_PRE;
                    w_pre_nxt   = 3'd0;
                    w_txd_nxt   = 8'h55;
                    w_en_nxt    = 1'b1;
                end
            end
            S_PRE: begin
                w_en_nxt  = 1'b1;
                w_cnt_nxt = 11'd0;
                w_crc_nxt = 32'hFFFFFFFF;
                if (r_pre == 3'd6) begin
                    w_state_nxt = S_SFD;
                    w_txd_nxt   = 8'hD5;
                end else begin
                    w_pre_nxt = r_pre + 3'd1;
                    w_txd_nxt = 8'h55;
                end
            end
            S_SFD, S_DATA: begin
                w_en_nxt = 1'b1;
                if (TX_VALID_i) begin
                    w_txd_nxt   = TX_DATA_i;
                    w_crc_nxt   = crc_byte(r_crc, TX_DATA_i);
                    w_cnt_nxt   = w_cnt_inc;
                    w_state_nxt = S_DATA;
                    if (TX_LAST_i) begin
                        w_idx_nxt   = 2'd0;
                        w_state_nxt = w_need_pad ? S_PAD : S_FCS;
                    end
                end else begin
                    w_er_nxt     = 1'b1;
                    w_aborts_nxt = r_aborts + 8'd1;
                    w_state_nxt  = S_DROP;
                end
            end
            S_PAD: begin
                w_en_nxt  = 1'b1;
                w_crc_nxt = crc_byte(r_crc, 8'h00);
                w_cnt_nxt = w_cnt_inc;
                if (!w_need_pad) begin
                    w_state_nxt = S_FCS;
                end
            end
            S_FCS: begin
                w_en_nxt  = 1'b1;
                w_txd_nxt = w_fcs_sh[7:0];
                w_idx_nxt = r_idx + 2'd1;
                if (r_idx == 2'd3) begin
                    w_frames_nxt = r_frames + 16'd1;
                    w_ifg_nxt    = 8'd0;
                    w_state_nxt  = S_IFG;
                end
            end
            S_DROP: begin
                if (TX_VALID_i && TX_LAST_i) begin
                    w_ifg_nxt   = 8'd0;
                    w_state_nxt = S_IFG;
                end
            end
            S_IFG: begin
                // First IFG cycle still carries the last FCS/abort byte.
                if (r_ifg == IFG_LAST) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_ifg_nxt = r_ifg + 8'd1;
                end
            end
        endcase
    end

    always_ff @(posedge GMII_TX_CLK_i or posedge RST_i) begin
        if (RST_i) begin
            r_state  <= S_IDLE;
            r_pre    <= 3'd0;
            r_idx    <= 2'd0;
            r_ifg    <= 8'd0;
            r_cnt    <= 11'd0;
            r_crc    <= 32'hFFFFFFFF;
            r_txd    <= 8'h00;
            r_en     <= 1'b0;
            r_er     <= 1'b0;
            r_frames <= 16'd0;
            r_aborts <= 8'd0;
        end else begin
            r_state  <= w_state_nxt;
            r_pre    <= w_pre_nxt;
            r_idx    <= w_idx_nxt;
            r_ifg    <= w_ifg_nxt;
            r_cnt    <= w_cnt_nxt;
            r_crc    <= w_crc_nxt;
            r_txd    <= w_txd_nxt;
            r_en     <= w_en_nxt;
            r_er     <= w_er_nxt;
            r_frames <= w_frames_nxt;
            r_aborts <= w_aborts_nxt;
        end
    end

    assign TX_READY_o    = (r_state == S_SFD) || (r_state == S_DATA)
                        || (r_state == S_DROP);
    assign TX_BUSY_o     = (r_state != S_IDLE);
    assign GMII_TX_TXD_o = r_txd;
    assign GMII_TX_EN_o  = r_en;
    assign GMII_TX_ER_o  = r_er;
    assign FRAME_CNT_o   = r_frames;
    assign ABORT_CNT_o   = r_aborts;

endmodule

// File: tb/tb_gmii_tx_framer.sv
// Directed bench for gmii_tx_framer: wire bytes are checked against a
// scoreboard filled when each frame is queued for transmission.
module tb_gmii_tx_framer;

    typedef struct packed {
        logic       v;
        logic       l;
        logic [7:0] d;
    } beat_t;

    logic       clk   = 1'b0;
    logic       rst   = 1'b1;
    logic [7:0] data  = 8'h00;
    logic       valid = 1'b0;
    logic       last  = 1'b0;
    logic       sel   = 1'b0;

    logic        rdy_a, en_a, er_a, busy_a;
    logic        rdy_b, en_b, er_b, busy_b;
    logic [7:0]  txd_a, txd_b, ab_a, ab_b;
    logic [15:0] fr_a, fr_b;
    logic        valid_a, valid_b;

    logic        m_ready, m_en, m_er, m_busy;
    logic [7:0]  m_txd, m_ab;
    logic [15:0] m_fr;

    always #4 clk = ~clk;

    assign valid_a = valid & ~sel;
    assign valid_b = valid & sel;

    gmii_tx_framer dut_a (
        .GMII_TX_CLK_i (clk),
        .RST_i         (rst),
        .TX_DATA_i     (data),
        .TX_VALID_i    (valid_a),
        .TX_LAST_i     (last),
        .TX_READY_o    (rdy_a),
        .GMII_TX_TXD_o (txd_a),
        .GMII_TX_EN_o  (en_a),
        .GMII_TX_ER_o  (er_a),
        .TX_BUSY_o     (busy_a),
        .FRAME_CNT_o   (fr_a),
        .ABORT_CNT_o   (ab_a)
    );

    gmii_tx_framer #(.IFG_BYTES(12), .MIN_FRAME_BYTES(0)) dut_b (
        .GMII_TX_CLK_i (clk),
        .RST_i         (rst),
        .TX_DATA_i     (data),
        .TX_VALID_i    (valid_b),
        .TX_LAST_i     (last),
        .TX_READY_o    (rdy_b),
        .GMII_TX_TXD_o (txd_b),
        .GMII_TX_EN_o  (en_b),
        .GMII_TX_ER_o  (er_b),
        .TX_BUSY_o     (busy_b),
        .FRAME_CNT_o   (fr_b),
        .ABORT_CNT_o   (ab_b)
    );

    assign m_ready = sel ? rdy_b  : rdy_a;
    assign m_en    = sel ? en_b   : en_a;
    assign m_er    = sel ? er_b   : er_a;
    assign m_busy  = sel ? busy_b : busy_a;
    assign m_txd   = sel ? txd_b  : txd_a;
    assign m_ab    = sel ? ab_b   : ab_a;
    assign m_fr    = sel ? fr_b   : fr_a;

    beat_t       sched[$];
    logic [8:0]  exp_q[$];
    int          len_q[$];
    int          gap_q[$];
    int          n_cmp   = 0;
    int          n_fail  = 0;
    int          acc     = 0;
    int          run_len = 0;
    int          gap     = 0;
    int          n       = 0;
    logic        prev_en = 1'b0;
    logic        seen    = 1'b0;
    logic [7:0]  pl[$];
    logic [31:0] crc_v;
    beat_t       bt;

    // Bit-serial reference CRC-32 (reflected, LSB of each byte first).
    function automatic logic [31:0] crc8(
        input logic [31:0] c,
        input logic [7:0]  d
    );
        logic [31:0] r;
        r = c;
        for (int b = 0; b < 8; b++) begin
            if (r[0] ^ d[b]) r = (r >> 1) ^ 32'hEDB88320;
            else             r = r >> 1;
        end
        return r;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic push_body(input logic [7:0] p[$], input int minb,
                             input bit mark_last,
                             output logic [31:0] c);
        beat_t b;
        c = 32'hFFFFFFFF;
        repeat (7) exp_q.push_back(9'h055);
        exp_q.push_back(9'h0D5);
        foreach (p[k]) begin
            exp_q.push_back({1'b0, p[k]});
            c   = crc8(c, p[k]);
            b.v = 1'b1;
            b.l = mark_last && (k == p.size() - 1);
            b.d = p[k];
            sched.push_back(b);
        end
        for (int k = p.size(); k < minb; k++) begin
            exp_q.push_back(9'h000);
            c = crc8(c, 8'h00);
        end
    endtask

    task automatic push_fcs(input logic [31:0] c);
        logic [31:0] f;
        f = ~c;
        exp_q.push_back({1'b0, f[7:0]});
        exp_q.push_back({1'b0, f[15:8]});
        exp_q.push_back({1'b0, f[23:16]});
        exp_q.push_back({1'b0, f[31:24]});
    endtask

    task automatic add_frame(input logic [7:0] p[$], input int minb);
        logic [31:0] c;
        push_body(p, minb, 1'b1, c);
        push_fcs(c);
    endtask

    task automatic clear_stats();
        len_q.delete();
        gap_q.delete();
        seen = 1'b0;
        gap  = 0;
    endtask

    // One clock: present the head beat, cross the edge, then sample.
    task automatic step();
        logic       r;
        beat_t      f;
        logic [8:0] e;
        f = '0;
        if (sched.size() != 0) f = sched[0];
        valid = f.v;
        last  = f.l;
        data  = f.d;
        r     = m_ready;
        @(posedge clk);
        #1;
        if (r && valid) acc++;
        if (r && sched.size() != 0) void'(sched.pop_front());
        if (m_er === 1'b1) begin
            n_cmp++;
            assert (m_en === 1'b1) else begin
                n_fail++;
                $error("FAIL er_without_en: en=%b required 1", m_en);
            end
        end
        if (m_en === 1'b1) begin
            n_cmp++;
            assert (exp_q.size() != 0) else begin
                n_fail++;
                $error("FAIL extra_byte: got %h, none expected",
                       {m_er, m_txd});
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                n_cmp++;
                assert ({m_er, m_txd} === e) else begin
                    n_fail++;
                    $error("FAIL wire_byte: {er,txd} %h expected %h",
                           {m_er, m_txd}, e);
                end
            end
            if (!prev_en) begin
                if (seen) gap_q.push_back(gap);
                seen    = 1'b1;
                gap     = 0;
                run_len = 0;
            end
            run_len++;
        end else begin
            if (prev_en) len_q.push_back(run_len);
            gap++;
        end
        prev_en = m_en;
    endtask

    task automatic run(input int budget);
        int k;
        k = 0;
        while ((sched.size() != 0 || m_busy) && k < budget) begin
            step();
            k++;
        end
        chk("run_timeout", 32'(k < budget), 32'd1);
        repeat (3) step();
    endtask

    task automatic chk_len(input string tag, input int exp);
        chk({tag, "_nrun"}, 32'(len_q.size()), 32'd1);
        if (len_q.size() != 0) chk({tag, "_len"}, 32'(len_q.pop_front()), 32'(exp));
    endtask

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_txd", 32'(m_txd), 32'h0);
        chk("rst_en", 32'(m_en), 32'h0);
        chk("rst_er", 32'(m_er), 32'h0);
        chk("rst_ready", 32'(m_ready), 32'h0);
        chk("rst_busy", 32'(m_busy), 32'h0);
        chk("rst_frames", 32'(m_fr), 32'h0);
        chk("rst_aborts", 32'(m_ab), 32'h0);
        rst = 1'b0;
        repeat (2) step();

        // 60-byte payload, no pad
        clear_stats();
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        add_frame(pl, 60);
        run(400);
        chk_len("t1", 72);
        chk("t1_left", 32'(exp_q.size()), 32'd0);
        chk("t1_frames", 32'(m_fr), 32'd1);
        chk("t1_aborts", 32'(m_ab), 32'd0);

        // 14-byte payload, 46 pad bytes
        clear_stats();
        pl.delete();
        for (int i = 0; i < 14; i++) pl.push_back(8'(8'hA0 + i));
        add_frame(pl, 60);
        run(400);
        chk_len("t2", 72);
        chk("t2_left", 32'(exp_q.size()), 32'd0);
        chk("t2_frames", 32'(m_fr), 32'd2);

        // back-to-back frames: gap of IFG+1
        clear_stats();
        pl.delete();
        for (int i = 0; i < 64; i++) pl.push_back(8'($urandom_range(255)));
        add_frame(pl, 60);
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'($urandom_range(255)));
        add_frame(pl, 60);
        run(600);
        chk("t4_nrun", 32'(len_q.size()), 32'd2);
        if (len_q.size() == 2) begin
            chk("t4_len0", 32'(len_q[0]), 32'd76);
            chk("t4_len1", 32'(len_q[1]), 32'd72);
        end
        chk("t4_ngap", 32'(gap_q.size()), 32'd1);
        if (gap_q.size() != 0) chk("t4_gap", 32'(gap_q[0]), 32'd13);
        chk("t4_left", 32'(exp_q.size()), 32'd0);
        chk("t4_frames", 32'(m_fr), 32'd4);

        // underrun after 20 bytes, then 5 beats to discard
        clear_stats();
        pl.delete();
        for (int i = 0; i < 20; i++) pl.push_back(8'(8'hC0 + i));
        push_body(pl, 0, 1'b0, crc_v);
        exp_q.push_back(9'h100);
        bt = '0;
        sched.push_back(bt);
        for (int i = 0; i < 5; i++) begin
            bt.v = 1'b1;
            bt.l = (i == 4);
            bt.d = 8'(8'hE0 + i);
            sched.push_back(bt);
        end
        run(400);
        chk_len("t5", 29);
        chk("t5_left", 32'(exp_q.size()), 32'd0);
        chk("t5_aborts", 32'(m_ab), 32'd1);
        chk("t5_frames", 32'(m_fr), 32'd4);

        // reset during payload byte 30
        clear_stats();
        pl.delete();
        for (int i = 0; i < 60; i++) pl.push_back(8'(i));
        add_frame(pl, 60);
        acc = 0;
        n   = 0;
        while (acc < 30 && n < 200) begin
            step();
            n++;
        end
        chk("t6_reach", 32'(acc), 32'd30);
        #3;
        rst = 1'b1;
        #1;
        chk("t6_txd", 32'(m_txd), 32'h0);
        chk("t6_en", 32'(m_en), 32'h0);
        chk("t6_er", 32'(m_er), 32'h0);
        chk("t6_ready", 32'(m_ready), 32'h0);
        chk("t6_frames", 32'(m_fr), 32'h0);
        chk("t6_aborts", 32'(m_ab), 32'h0);
        sched.delete();
        step();
        exp_q.delete();
        clear_stats();
        rst = 1'b0;
        repeat (2) step();
        add_frame(pl, 60);
        run(400);
        chk_len("t6b", 72);
        chk("t6b_left", 32'(exp_q.size()), 32'd0);
        chk("t6b_frames", 32'(m_fr), 32'd1);

        // MIN_FRAME_BYTES=0, "123456789": known CRC-32 check value
        sel = 1'b1;
        repeat (2) step();
        clear_stats();
        pl.delete();
        for (int i = 0; i < 9; i++) pl.push_back(8'(8'h31 + i));
        push_body(pl, 0, 1'b1, crc_v);
        exp_q.push_back(9'h026);
        exp_q.push_back(9'h039);
        exp_q.push_back(9'h0F4);
        exp_q.push_back(9'h0CB);
        run(200);
        chk_len("t3", 21);
        chk("t3_left", 32'(exp_q.size()), 32'd0);
        chk("t3_frames", 32'(m_fr), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
